// File: rtl/coherence_bus_arbiter.sv
// Snooping coherence bus arbiter: round-robin selection of one core's miss or upgrade,
// broadcast snoop to the other cores, fill-source selection, then grant until the core lets go.
module coherence_bus_arbiter #(
    parameter int NUM_CPU   = 4,
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 16,
    parameter int SNOOP_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CPU-1:0]        read_miss,
    input  logic [NUM_CPU-1:0]        write_miss,
    input  logic [NUM_CPU-1:0]        invalidate,
    input  logic [NUM_CPU*ADDR_W-1:0] req_addr,
    input  logic [NUM_CPU-1:0]        search_found,
    input  logic [NUM_CPU*DATA_W-1:0] cpu_data,
    output logic [NUM_CPU-1:0]        cpu_search,
    output logic [ADDR_W-1:0]         boci,
    output logic [NUM_CPU-1:0]        grant,
    output logic [NUM_CPU*2-1:0]      cpu_datasel,
    output logic [NUM_CPU-1:0]        invalidate_out,
    output logic [DATA_W-1:0]         other_proc_data,
    output logic                      busy
);
    localparam int IDX_W = $clog2(NUM_CPU);
    localparam int CNT_W = 2;

    // state   | meaning
    // IDLE    | waiting for any request; winner latched on exit
    // SNOOP   | strobing other cores for SNOOP_LAT cycles
    // RESP    | one cycle: invalidate pulse, fill source decided
    // GRANT   | winner owns the bus until all its requests drop
    // RELEASE | outputs cleared, round-robin pointer advanced
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SNOOP   = 3'd1,
        S_RESP    = 3'd2,
        S_GRANT   = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_INV   = 2'd2
    } op_t;

    state_t              r_state, w_next;
    op_t                 r_op, w_pick_op;
    logic [IDX_W-1:0]    r_rr_ptr, r_win, w_pick, w_sup;
    logic [ADDR_W-1:0]   r_addr;
    logic [CNT_W-1:0]    r_cnt;
    logic [NUM_CPU-1:0]  r_found, w_req, w_win_oh, w_found_m;
    logic [1:0]          r_sel;
    logic [DATA_W-1:0]   r_opd;

    assign w_req     = read_miss | write_miss | invalidate;
    assign w_win_oh  = NUM_CPU'(1) << r_win;
    assign w_found_m = search_found & ~w_win_oh;

    // Scan downward so the requester closest to r_rr_ptr is the last assignment.
    always_comb begin
        int j;
        j      = 0;
        w_pick = r_rr_ptr;
        for (int i = NUM_CPU - 1; i >= 0; i--) begin
            j = int'(r_rr_ptr) + i;
            if (j >= NUM_CPU) j = j - NUM_CPU;
            if (w_req[j]) w_pick = IDX_W'(j);
        end
    end

    always_comb begin
        w_pick_op = OP_READ;
        if (write_miss[w_pick])      w_pick_op = OP_WRITE;
        else if (invalidate[w_pick]) w_pick_op = OP_INV;
    end

    // Lowest-index responding core supplies the data.
    always_comb begin
        w_sup = '0;
        for (int i = NUM_CPU - 1; i >= 0; i--) begin
            if (w_found_m[i]) w_sup = IDX_W'(i);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (|w_req) w_next = S_SNOOP;
            S_SNOOP:   if (r_cnt == '0) w_next = S_RESP;
            S_RESP:    w_next = S_GRANT;
            S_GRANT:   if (!w_req[r_win]) w_next = S_RELEASE;
            S_RELEASE: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_op     <= OP_READ;
            r_rr_ptr <= '0;
            r_win    <= '0;
            r_addr   <= '0;
            r_cnt    <= '0;
            r_found  <= '0;
            r_sel    <= 2'b00;
            r_opd    <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (|w_req) begin
                        r_win  <= w_pick;
                        r_op   <= w_pick_op;
                        r_addr <= req_addr[w_pick*ADDR_W +: ADDR_W];
                        r_cnt  <= CNT_W'(SNOOP_LAT - 1);
                    end
                end
                S_SNOOP: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_found <= w_found_m;
                        if (r_op == OP_INV) begin
                            r_sel <= 2'b00;
                            r_opd <= '0;
                        end else if (|w_found_m) begin
                            r_sel <= 2'b10;
                            r_opd <= cpu_data[w_sup*DATA_W +: DATA_W];
                        end else begin
                            r_sel <= 2'b01;
                            r_opd <= '0;
                        end
                    end
                end
                S_RELEASE: begin
                    r_rr_ptr <= (r_win == IDX_W'(NUM_CPU - 1)) ? '0 : r_win + 1'b1;
                    r_found  <= '0;
                    r_sel    <= 2'b00;
                    r_opd    <= '0;
                end
                default: ;
            endcase
        end
    end

    // Outputs decode from registered state only, so reset clears them immediately.
    always_comb begin
        busy            = (r_state != S_IDLE);
        cpu_search      = '0;
        boci            = '0;
        grant           = '0;
        invalidate_out  = '0;
        cpu_datasel     = '0;
        other_proc_data = '0;
        case (r_state)
            S_SNOOP: begin
                cpu_search = ~w_win_oh;
                boci       = r_addr;
            end
            S_RESP: begin
                boci            = r_addr;
                other_proc_data = r_opd;
                if (r_op != OP_READ) invalidate_out = r_found;
            end
            S_GRANT: begin
                boci            = r_addr;
                grant           = w_win_oh;
                other_proc_data = r_opd;
            end
            default: ;
        endcase
        if (r_state == S_RESP || r_state == S_GRANT) begin
            for (int i = 0; i < NUM_CPU; i++) begin
                if (IDX_W'(i) == r_win) cpu_datasel[2*i +: 2] = r_sel;
            end
        end
    end

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Scoreboard bench for coherence_bus_arbiter: the driver queues the expected outcome of each
// transaction; a negedge monitor collects snoop/invalidate activity and checks it at each grant.
module tb_coherence_bus_arbiter;
    localparam int NC = 4;
    localparam int AW = 13;
    localparam int DW = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NC-1:0]    read_miss = '0, write_miss = '0, invalidate = '0, search_found = '0;
    logic [NC*AW-1:0] req_addr = '0;
    logic [NC*DW-1:0] cpu_data = '0;
    logic [NC-1:0]    cpu_search, grant, invalidate_out;
    logic [AW-1:0]    boci;
    logic [NC*2-1:0]  cpu_datasel;
    logic [DW-1:0]    other_proc_data;
    logic             busy;

    coherence_bus_arbiter #(.NUM_CPU(NC), .ADDR_W(AW), .DATA_W(DW), .SNOOP_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .read_miss(read_miss), .write_miss(write_miss), .invalidate(invalidate),
        .req_addr(req_addr), .search_found(search_found), .cpu_data(cpu_data),
        .cpu_search(cpu_search), .boci(boci), .grant(grant), .cpu_datasel(cpu_datasel),
        .invalidate_out(invalidate_out), .other_proc_data(other_proc_data), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NC-1:0]   grant;
        logic [NC*2-1:0] sel;
        logic [DW-1:0]   opd;
        logic [NC-1:0]   inv;
        logic [NC-1:0]   srch;
        logic [AW-1:0]   boci;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [NC-1:0] g, input logic [NC*2-1:0] s, input logic [DW-1:0] d,
                        input logic [NC-1:0] inv, input logic [NC-1:0] sr, input logic [AW-1:0] a);
        exp_t e;
        e.grant = g; e.sel = s; e.opd = d; e.inv = inv; e.srch = sr; e.boci = a;
        sb.push_back(e);
    endtask

    // Monitor state
    logic [NC-1:0] cap_search, cap_inv, prev_grant;
    logic [AW-1:0] cap_boci;
    int            inv_cycles, busy_cycles;

    always @(negedge clk) begin
        if (!rst_n) begin
            cap_search = '0; cap_boci = '0; cap_inv = '0; prev_grant = '0;
            inv_cycles = 0;  busy_cycles = 0;
        end else begin
            if (cpu_search != '0) begin
                cap_search = cpu_search;
                cap_boci   = boci;
            end
            if (invalidate_out != '0) begin
                cap_inv = invalidate_out;
                inv_cycles++;
            end
            if (grant != '0 && prev_grant == '0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_grant", 32'(grant), 32'h0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("grant",       32'(grant),            32'(e.grant));
                    chk("grant_onehot", 32'($countones(grant)), 32'd1);
                    chk("datasel",     32'(cpu_datasel),      32'(e.sel));
                    chk("other_data",  32'(other_proc_data),  32'(e.opd));
                    chk("inval_vec",   32'(cap_inv),          32'(e.inv));
                    chk("inval_cycles", 32'(inv_cycles),      (e.inv != '0) ? 32'd1 : 32'd0);
                    chk("cpu_search",  32'(cap_search),       32'(e.srch));
                    chk("boci",        32'(cap_boci),         32'(e.boci));
                    chk("latency",     32'(busy_cycles),      32'd2);
                end
                cap_search = '0; cap_boci = '0; cap_inv = '0; inv_cycles = 0;
            end else if (busy && grant == '0) begin
                busy_cycles++;
            end
            if (!busy) busy_cycles = 0;
            prev_grant = grant;
        end
    end

    task automatic wait_grant(output logic [NC-1:0] g);
        int n;
        n = 0;
        while (grant == '0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        g = grant;
        chk("grant_seen", 32'(grant != '0), 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("idle_seen", 32'(busy), 32'd0);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_busy"},   32'(busy),            32'd0);
        chk({tag, "_grant"},  32'(grant),           32'd0);
        chk({tag, "_search"}, 32'(cpu_search),      32'd0);
        chk({tag, "_inval"},  32'(invalidate_out),  32'd0);
        chk({tag, "_sel"},    32'(cpu_datasel),     32'd0);
        chk({tag, "_boci"},   32'(boci),            32'd0);
        chk({tag, "_data"},   32'(other_proc_data), 32'd0);
    endtask

    // Hold the grant a couple of cycles, drop every request, and confirm the bus goes quiet.
    task automatic finish_txn(input string tag);
        logic [NC-1:0] g;
        wait_grant(g);
        repeat (2) @(negedge clk);
        #2;
        read_miss = '0; write_miss = '0; invalidate = '0;
        wait_idle();
        #1;
        check_quiet(tag);
        search_found = '0;
        cpu_data     = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NC-1:0] g;
        int            core;

        #3;
        check_quiet("reset");
        @(negedge clk); #2 rst_n = 1'b1;

        // core2 read miss, no snoop hit: memory fill
        req_addr[2*AW +: AW] = 13'h0A5;
        push(4'b0100, 8'h10, 16'h0, 4'b0000, 4'b1011, 13'h0A5);
        @(negedge clk); #2 read_miss[2] = 1'b1;
        finish_txn("t1");

        // core0 read miss, cores 1 and 3 hit: core1 supplies
        req_addr[0 +: AW] = 13'h123;
        search_found = 4'b1010;
        cpu_data[1*DW +: DW] = 16'hBEEF;
        cpu_data[3*DW +: DW] = 16'h1234;
        push(4'b0001, 8'h02, 16'hBEEF, 4'b0000, 4'b1110, 13'h123);
        #2 read_miss[0] = 1'b1;
        finish_txn("t2");

        // core3 write miss at the top address, core0 hit
        req_addr[3*AW +: AW] = 13'h1FFF;
        search_found = 4'b0001;
        cpu_data[0 +: DW] = 16'h5A5A;
        push(4'b1000, 8'h80, 16'h5A5A, 4'b0001, 4'b0111, 13'h1FFF);
        #2 write_miss[3] = 1'b1;
        finish_txn("t3");

        // core1 read+write miss: write wins; its own hit bit is masked, core2 supplies
        req_addr[1*AW +: AW] = 13'h0042;
        search_found = 4'b0110;
        cpu_data[1*DW +: DW] = 16'hFFFF;
        cpu_data[2*DW +: DW] = 16'hC0DE;
        push(4'b0010, 8'h08, 16'hC0DE, 4'b0100, 4'b1101, 13'h0042);
        #2 begin read_miss[1] = 1'b1; write_miss[1] = 1'b1; end
        finish_txn("t4");

        // core2 upgrade: sharers invalidated, no fill source, no forwarded data
        req_addr[2*AW +: AW] = 13'h0ABC;
        search_found = 4'b1011;
        cpu_data[0 +: DW] = 16'h7777;
        push(4'b0100, 8'h00, 16'h0, 4'b1011, 4'b1011, 13'h0ABC);
        #2 invalidate[2] = 1'b1;
        finish_txn("t5");

        // reset mid-SNOOP: pointer was at 3, so after reset core1 must win
        req_addr[1*AW +: AW] = 13'h0111;
        req_addr[3*AW +: AW] = 13'h0333;
        push(4'b0010, 8'h04, 16'h0, 4'b0000, 4'b1101, 13'h0111);
        #2 begin read_miss[1] = 1'b1; read_miss[3] = 1'b1; end
        begin
            int n;
            n = 0;
            while (cpu_search == '0 && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("abort_in_snoop", 32'(cpu_search), 32'b0111);
        end
        #2 rst_n = 1'b0;
        #1 check_quiet("abort");
        @(negedge clk); #2 rst_n = 1'b1;
        finish_txn("t6");

        // all four request continuously from reset: strict 0,1,2,3,0 rotation
        rst_n = 1'b0;
        for (int k = 0; k < NC; k++) req_addr[k*AW +: AW] = 13'(13'h100 + k);
        for (int k = 0; k < 5; k++) begin
            int c;
            c = k % NC;
            push(4'(1 << c), 8'(1 << (2*c)), 16'h0, 4'b0000, 4'(~(4'(1 << c))), 13'(13'h100 + c));
        end
        read_miss = 4'b1111;
        @(negedge clk); #2 rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_grant(g);
            core = 0;
            for (int b = 0; b < NC; b++) if (g[b]) core = b;
            @(negedge clk); #2 read_miss[core] = 1'b0;
            wait_idle();
            #2 read_miss[core] = 1'b1;
        end
        #1 read_miss = '0;
        wait_idle();
        repeat (3) @(negedge clk);
        #1 check_quiet("end");
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
